// File: rtl/gf2_seq_poly_divider_if.sv
// Operand/result bundle for the sequential GF(2) polynomial divider.
// Optional `exact` flag is present only when GF2DIV_EXACT_EN is defined.
interface gf2_seq_poly_divider_if #(
  parameter int N = 256
);
  logic             start;
  logic [2*N-1:0]   w;
  logic [N-1:0]     v;
  logic [2*N-1:0]   q;
  logic [N-1:0]     r;
  logic             done;
  logic             busy;
  logic             err;
`ifdef GF2DIV_EXACT_EN
  logic             exact;

  modport master (output start, w, v, input q, r, done, busy, err, exact);
  modport slave  (input start, w, v, output q, r, done, busy, err, exact);
`else
  modport master (output start, w, v, input q, r, done, busy, err);
  modport slave  (input start, w, v, output q, r, done, busy, err);
`endif
endinterface

// File: rtl/gf2_seq_poly_divider.sv
// Sequential GF(2) long divider W = Q*V + R, BPC dividend bits per RUN cycle, MSB first.
// Define GF2DIV_EXACT_EN to add the `exact` (zero remainder, no error) result flag.
module gf2_seq_poly_divider #(
  parameter int N   = 256,
  parameter int BPC = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  gf2_seq_poly_divider_if.slave div_if
);

  localparam int K  = (2 * N) / BPC;
  localparam int DW = $clog2(N + 1);
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  if (((2 * N) % BPC) != 0) begin : g_bad_bpc
    $error("gf2_seq_poly_divider: BPC must divide 2N");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   w_q, w_d;
  logic [N-1:0]     v_q, v_d;
  logic [DW-1:0]    d_q, d_d;
  logic [N:0]       r_q, r_d;
  logic [2*N-1:0]   quo_q, quo_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
`ifdef GF2DIV_EXACT_EN
  logic             exact_q, exact_d;
`endif

  logic [DW-1:0]    deg_v;
  logic [BPC-1:0]   qbits;
  logic [N:0]       r_last;
  logic [2*N-1:0]   quo_next;
  logic [2*N-1:0]   w_next;

  // One long-division step per generate slice, chained combinationally.
  for (genvar gi = 0; gi < BPC; gi++) begin : g_step
    logic [N:0] r_in;
    logic [N:0] r_sh;
    logic [N:0] r_out;
    logic       qbit;

    if (gi == 0) begin : g_first
      assign r_in = r_q;
    end else begin : g_chain
      assign r_in = g_step[gi-1].r_out;
    end

    assign r_sh  = {r_in[N-1:0], w_q[2*N-1-gi]};
    assign qbit  = r_sh[d_q];
    assign r_out = qbit ? (r_sh ^ {1'b0, v_q}) : r_sh;
    assign qbits[BPC-1-gi] = qbit;
  end

  assign r_last   = g_step[BPC-1].r_out;
  assign quo_next = (quo_q << BPC) | (2 * N)'(qbits);
  assign w_next   = w_q << BPC;

  always_comb begin
    deg_v = '0;
    for (int i = 0; i < N; i++) begin
      if (v_q[i]) begin
        deg_v = DW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    v_d     = v_q;
    d_d     = d_q;
    r_d     = r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef GF2DIV_EXACT_EN
    exact_d = exact_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (div_if.start) begin
          w_d     = div_if.w;
          v_d     = div_if.v;
          quo_d   = '0;
          err_d   = 1'b0;
`ifdef GF2DIV_EXACT_EN
          exact_d = 1'b0;
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (v_q == '0) begin
          err_d   = 1'b1;
          quo_d   = '0;
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          d_d     = deg_v;
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_d   = r_last;
        quo_d = quo_next;
        w_d   = w_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          rem_d   = r_last[N-1:0];
`ifdef GF2DIV_EXACT_EN
          exact_d = (r_last[N-1:0] == '0);
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      v_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef GF2DIV_EXACT_EN
      exact_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      v_q     <= v_d;
      d_q     <= d_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef GF2DIV_EXACT_EN
      exact_q <= exact_d;
`endif
    end
  end

  assign div_if.q    = quo_q;
  assign div_if.r    = rem_q;
  assign div_if.done = (state_q == S_DONE);
  assign div_if.busy = (state_q == S_LOAD) || (state_q == S_RUN);
  assign div_if.err  = err_q;
`ifdef GF2DIV_EXACT_EN
  assign div_if.exact = exact_q;
`endif

endmodule

// File: tb/tb_gf2_seq_poly_divider.sv
// Directed bench: N=8 at BPC=1 and BPC=4, plus an N=256 product/operand round trip.
module tb_gf2_seq_poly_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  gf2_seq_poly_divider_if #(.N(8))   a_if ();
  gf2_seq_poly_divider_if #(.N(8))   b_if ();
  gf2_seq_poly_divider_if #(.N(256)) c_if ();

  gf2_seq_poly_divider #(.N(8), .BPC(1)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .div_if(a_if.slave)
  );

  gf2_seq_poly_divider #(.N(8), .BPC(4)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .div_if(b_if.slave)
  );

  gf2_seq_poly_divider #(.N(256), .BPC(8)) dut_c (
    .clk_i (clk),
    .rst_i (rst),
    .div_if(c_if.slave)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start an N=8 BPC=1 division; lat = edges after the start edge until done.
  task automatic op_a(input logic [15:0] w, input logic [7:0] v,
                      output int lat, output logic done_after_start);
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.w     = w;
    a_if.v     = v;
    @(posedge clk);
    #1;
    a_if.start       = 1'b0;
    done_after_start = a_if.done;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (a_if.done) break;
    end
    $display("op W=%h V=%h -> Q=%h R=%h err=%0b lat=%0d", w, v, a_if.q, a_if.r, a_if.err, lat);
  endtask

  function automatic logic [511:0] clmul(input logic [127:0] a, input logic [127:0] b);
    logic [511:0] p;
    p = '0;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) p = p ^ (512'(a) << i);
    end
    return p;
  endfunction

  int           lat;
  logic         d0;
  logic [127:0] opa, opb;

  initial begin
    rst = 1'b1;
    a_if.start = 1'b0; a_if.w = '0; a_if.v = '0;
    b_if.start = 1'b0; b_if.w = '0; b_if.v = '0;
    c_if.start = 1'b0; c_if.w = '0; c_if.v = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q",    512'(a_if.q),    512'(0));
    chk("rst_r",    512'(a_if.r),    512'(0));
    chk("rst_done", 512'(a_if.done), 512'(0));
    chk("rst_busy", 512'(a_if.busy), 512'(0));
    chk("rst_err",  512'(a_if.err),  512'(0));
    @(negedge clk);
    rst = 1'b0;

    // Case 1: exact division
    op_a(16'h0031, 8'h07, lat, d0);
    chk("c1_done", 512'(a_if.done), 512'(1));
    chk("c1_lat",  512'(lat),       512'(17));
    chk("c1_q",    512'(a_if.q),    512'(16'h000B));
    chk("c1_r",    512'(a_if.r),    512'(8'h00));
    chk("c1_err",  512'(a_if.err),  512'(0));
    chk("c1_busy", 512'(a_if.busy), 512'(0));
`ifdef GF2DIV_EXACT_EN
    chk("c1_exact", 512'(a_if.exact), 512'(1));
`endif

    // Case 2: nonzero remainder
    op_a(16'h0032, 8'h07, lat, d0);
    chk("c2_q", 512'(a_if.q), 512'(16'h000B));
    chk("c2_r", 512'(a_if.r), 512'(8'h03));
`ifdef GF2DIV_EXACT_EN
    chk("c2_exact", 512'(a_if.exact), 512'(0));
`endif

    // Case 3: divide by zero, then divide by one
    op_a(16'hBEEF, 8'h00, lat, d0);
    chk("c3_err", 512'(a_if.err), 512'(1));
    chk("c3_lat", 512'(lat),      512'(1));
    chk("c3_q",   512'(a_if.q),   512'(0));
    chk("c3_r",   512'(a_if.r),   512'(0));
    op_a(16'hBEEF, 8'h01, lat, d0);
    chk("c3b_q",   512'(a_if.q),   512'(16'hBEEF));
    chk("c3b_r",   512'(a_if.r),   512'(0));
    chk("c3b_err", 512'(a_if.err), 512'(0));

    // Boundaries: W=0, deg W < deg V, deg V = N-1
    op_a(16'h0000, 8'h07, lat, d0);
    chk("w0_q",   512'(a_if.q),   512'(0));
    chk("w0_r",   512'(a_if.r),   512'(0));
    chk("w0_err", 512'(a_if.err), 512'(0));
    op_a(16'h0005, 8'h80, lat, d0);
    chk("small_q", 512'(a_if.q), 512'(0));
    chk("small_r", 512'(a_if.r), 512'(8'h05));
    op_a(16'hFFFF, 8'h80, lat, d0);
    chk("top_q", 512'(a_if.q), 512'(16'h01FF));
    chk("top_r", 512'(a_if.r), 512'(8'h7F));

    // Case 4: reset during RUN
    @(negedge clk);
    a_if.start = 1'b1; a_if.w = 16'h0031; a_if.v = 8'h07;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_run_q",    512'(a_if.q),    512'(0));
    chk("rst_run_r",    512'(a_if.r),    512'(0));
    chk("rst_run_done", 512'(a_if.done), 512'(0));
    chk("rst_run_busy", 512'(a_if.busy), 512'(0));
    chk("rst_run_err",  512'(a_if.err),  512'(0));
    @(negedge clk);
    rst = 1'b0;
    op_a(16'h0031, 8'h07, lat, d0);
    chk("c4_q",   512'(a_if.q), 512'(16'h000B));
    chk("c4_lat", 512'(lat),    512'(17));

    // Case 5: start during RUN is ignored
    @(negedge clk);
    a_if.start = 1'b1; a_if.w = 16'h0031; a_if.v = 8'h07;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) begin
        a_if.start = 1'b1; a_if.w = 16'hFFFF; a_if.v = 8'h03;
      end else begin
        a_if.start = 1'b0;
      end
      if (a_if.done) break;
    end
    $display("op W=0031 V=07 with mid-run start -> Q=%h R=%h lat=%0d", a_if.q, a_if.r, lat);
    chk("c5_lat", 512'(lat),    512'(17));
    chk("c5_q",   512'(a_if.q), 512'(16'h000B));
    chk("c5_r",   512'(a_if.r), 512'(8'h00));

    // Back-to-back start while done=1
    op_a(16'h0032, 8'h07, lat, d0);
    chk("c5b_done_drop", 512'(d0),     512'(0));
    chk("c5b_q",         512'(a_if.q), 512'(16'h000B));
    chk("c5b_r",         512'(a_if.r), 512'(8'h03));

    // Case 6a: BPC=4
    @(negedge clk);
    b_if.start = 1'b1; b_if.w = 16'h0031; b_if.v = 8'h07;
    @(posedge clk);
    #1;
    b_if.start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (b_if.done) break;
    end
    $display("op BPC=4 W=0031 V=07 -> Q=%h R=%h lat=%0d", b_if.q, b_if.r, lat);
    chk("c6_lat", 512'(lat),    512'(5));
    chk("c6_q",   512'(b_if.q), 512'(16'h000B));
    chk("c6_r",   512'(b_if.r), 512'(8'h00));

    // Case 6b: N=256 round trip of a random product
    opa = {$urandom, $urandom, $urandom, $urandom};
    opb = {$urandom, $urandom, $urandom, $urandom};
    opb[127] = 1'b1;
    @(negedge clk);
    c_if.start = 1'b1; c_if.w = clmul(opa, opb); c_if.v = 256'(opb);
    @(posedge clk);
    #1;
    c_if.start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (c_if.done) break;
    end
    $display("op N=256 a=%h b=%h -> lat=%0d err=%0b", opa, opb, lat, c_if.err);
    chk("c6n_lat", 512'(lat),      512'(65));
    chk("c6n_q",   512'(c_if.q),   512'(opa));
    chk("c6n_r",   512'(c_if.r),   512'(0));
    chk("c6n_err", 512'(c_if.err), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
